// File: rtl/calc_seq_core_if.sv
// ============================================================================
// Module   : calc_seq_core_if
// Brief    : Key, operand and result bundle for the calculator sequencer core.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface calc_seq_core_if #(
    parameter int WIDTH = 4
);
    logic [1:0]         key;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic [1:0]         op;
    logic [1:0]         mode;
    logic [2*WIDTH-1:0] result;
    logic               ovf;
    logic               busy;

    modport master (output key, x, y, op, input  mode, result, ovf, busy);
    modport slave  (input  key, x, y, op, output mode, result, ovf, busy);
endinterface

`default_nettype wire

// File: rtl/calc_seq_core.sv
// ============================================================================
// Module   : calc_seq_core
// Brief    : Debounced mode keys, registered ALU and sequential restoring divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_seq_core #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 500000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    calc_seq_core_if.slave  bus
);

    localparam int c_DBW = $clog2(DEBOUNCE);
    localparam int c_DCW = $clog2(WIDTH);
    localparam logic [c_DBW-1:0] c_DB_MAX   = c_DBW'(DEBOUNCE - 1);
    localparam logic [c_DCW-1:0] c_DCNT_MAX = c_DCW'(WIDTH - 1);
    localparam logic [1:0] c_MODE_ARITH = 2'd0;
    localparam logic [1:0] c_MODE_LOGIC = 2'd1;
    localparam logic [1:0] c_MODE_CMP   = 2'd2;
    localparam logic [1:0] c_MODE_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [1:0] r_sync_vld;
    logic [1:0] w_press;
    logic [1:0] r_mode;

    // Marks when the synchroniser output reflects the real pins after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync_vld <= '0;
        else        r_sync_vld <= {r_sync_vld[0], 1'b1};
    end

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             r_s1;
        logic             r_s2;
        logic             r_level;
        logic             r_armed;
        logic [c_DBW-1:0] r_cnt;
        logic             w_accept;

        assign w_accept = (r_s2 != r_level) && (r_cnt == c_DB_MAX);

        // Presses are ignored until the key has been seen released, so a key
        // held through reset cannot fire.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1    <= 1'b1;
                r_s2    <= 1'b1;
                r_level <= 1'b1;
                r_armed <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1 <= bus.key[k];
                r_s2 <= r_s1;
                if (r_s2 == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt   <= '0;
                    r_level <= r_s2;
                end else begin
                    r_cnt <= r_cnt + c_DBW'(1);
                end
                if (r_sync_vld[1] && r_s2 && r_level) r_armed <= 1'b1;
            end
        end

        assign w_press[k] = w_accept && !r_s2 && r_armed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= c_MODE_ARITH;
        end else begin
            case (w_press)
                2'b01:   r_mode <= r_mode + 2'd1;
                2'b10:   r_mode <= r_mode - 2'd1;
                default: r_mode <= r_mode;
            endcase
        end
    end

    // ---------------- combinational ALU ----------------
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_res;
    logic               w_ovf;

    assign w_sum = {1'b0, bus.x} + {1'b0, bus.y};

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (r_mode)
            c_MODE_ARITH: begin
                case (bus.op)
                    2'b00: begin
                        w_res = {{(WIDTH-1){1'b0}}, w_sum};
                        w_ovf = w_sum[WIDTH];
                    end
                    2'b01: begin
                        w_res[WIDTH-1:0] = bus.x - bus.y;
                        w_ovf            = bus.x < bus.y;
                    end
                    2'b10:   w_res = {{WIDTH{1'b0}}, bus.x} * {{WIDTH{1'b0}}, bus.y};
                    default: w_res = '0;
                endcase
            end
            c_MODE_LOGIC: begin
                case (bus.op)
                    2'b00:   w_res[WIDTH-1:0] = bus.x & bus.y;
                    2'b01:   w_res[WIDTH-1:0] = bus.x | bus.y;
                    2'b10:   w_res[WIDTH-1:0] = bus.x ^ bus.y;
                    default: w_res[WIDTH-1:0] = ~bus.x;
                endcase
            end
            c_MODE_CMP: begin
                case (bus.op)
                    2'b00:   w_res[0] = bus.x == bus.y;
                    2'b01:   w_res[0] = bus.x > bus.y;
                    2'b10:   w_res[0] = bus.x < bus.y;
                    default: w_res[WIDTH-1:0] = (bus.x > bus.y) ? bus.x : bus.y;
                endcase
            end
            default: w_res = '0;
        endcase
    end

    // ---------------- divide sequencer ----------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic [c_DCW-1:0] r_dcnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic             r_last_vld;
    logic [WIDTH-1:0] r_last_x;
    logic [WIDTH-1:0] r_last_y;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_div_sel;
    logic             w_y_zero;
    logic             w_new_ops;
    logic             w_ops_chg;

    assign w_div_sel = (r_mode == c_MODE_ARITH) && (bus.op == 2'b11);
    assign w_y_zero  = (bus.y == '0);
    assign w_new_ops = !r_last_vld || (bus.x != r_last_x) || (bus.y != r_last_y);
    assign w_ops_chg = (bus.x != r_dvd) || (bus.y != r_dvs);
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_div_sel && !w_y_zero && w_new_ops) begin
                    w_state_nxt = S_DIV;
                    w_load      = 1'b1;
                end
            end
            S_DIV: begin
                if (!w_div_sel || w_y_zero) w_state_nxt = S_IDLE;
                else if (w_ops_chg)         w_load      = 1'b1;
                else if (r_dcnt == c_DCNT_MAX) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One restoring step per DIV cycle; the quotient shifts in where the
    // dividend shifts out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
        end else if (w_load) begin
            r_dcnt <= '0;
            r_rem  <= '0;
            r_quo  <= bus.x;
            r_dvd  <= bus.x;
            r_dvs  <= bus.y;
        end else if (r_state == S_DIV) begin
            r_dcnt <= r_dcnt + c_DCW'(1);
            r_rem  <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_quo  <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        end
    end

    // ---------------- result register ----------------
    logic [2*WIDTH-1:0] r_result;
    logic               r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_last_vld <= 1'b0;
            r_last_x   <= '0;
            r_last_y   <= '0;
        end else begin
            if (!w_div_sel || w_y_zero) begin
                r_last_vld <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_last_vld <= 1'b1;
                r_last_x   <= r_dvd;
                r_last_y   <= r_dvs;
            end
            if (r_mode != c_MODE_HOLD) begin
                if (w_div_sel) begin
                    if (w_y_zero) begin
                        r_result <= '1;
                        r_ovf    <= 1'b1;
                    end else if (r_state == S_DONE) begin
                        r_result <= {r_rem, r_quo};
                        r_ovf    <= 1'b0;
                    end
                end else begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                end
            end
        end
    end

    assign bus.mode   = r_mode;
    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
    assign bus.busy   = (r_state == S_DIV);

endmodule

`default_nettype wire

// File: tb/tb_calc_seq_core.sv
// ============================================================================
// Module   : tb_calc_seq_core
// Brief    : Directed self-checking bench for calc_seq_core (WIDTH=4, DEBOUNCE=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_calc_seq_core;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    calc_seq_core_if #(.WIDTH(4)) bus ();

    calc_seq_core #(
        .WIDTH    (4),
        .DEBOUNCE (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic press(input logic [1:0] which);
        bus.key = ~which;
        tick(8);
        bus.key = 2'b11;
        tick(8);
    endtask

    task automatic set_ops(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        bus.op = op;
        bus.x  = x;
        bus.y  = y;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        bus.key = 2'b11;
        set_ops(2'b00, 4'd0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_result_async", bus.result, 16'h00);
        check("rst_busy_async", bus.busy, 16'h0);
        tick(3);
        check("rst_mode", bus.mode, 16'h0);
        check("rst_result", bus.result, 16'h00);
        check("rst_ovf", bus.ovf, 16'h0);
        rst_n = 1'b1;
        tick(5);

        // short glitch rejected, long hold gives one increment
        bus.key = 2'b10; tick(3); bus.key = 2'b11; tick(10);
        check("glitch_mode", bus.mode, 16'h0);
        bus.key = 2'b10; tick(10); bus.key = 2'b11; tick(8);
        check("hold_press_mode", bus.mode, 16'h1);

        // logical mode
        set_ops(2'b00, 4'hC, 4'hA); tick(1); check("and", bus.result, 16'h08);
        set_ops(2'b01, 4'hC, 4'hA); tick(1); check("or", bus.result, 16'h0E);
        set_ops(2'b10, 4'hC, 4'hA); tick(1); check("xor", bus.result, 16'h06);
        set_ops(2'b11, 4'hC, 4'hA); tick(1); check("not", bus.result, 16'h03);
        check("logic_ovf", bus.ovf, 16'h0);

        // comparison mode
        press(2'b01);
        check("mode_cmp", bus.mode, 16'h2);
        set_ops(2'b00, 4'd6, 4'd9); tick(1); check("eq_false", bus.result, 16'h00);
        set_ops(2'b00, 4'd7, 4'd7); tick(1); check("eq_true", bus.result, 16'h01);
        set_ops(2'b01, 4'd6, 4'd9); tick(1); check("gt_false", bus.result, 16'h00);
        set_ops(2'b10, 4'd6, 4'd9); tick(1); check("lt_true", bus.result, 16'h01);
        set_ops(2'b11, 4'd6, 4'd9); tick(1); check("max_y", bus.result, 16'h09);
        set_ops(2'b01, 4'd9, 4'd6); tick(1); check("gt_true", bus.result, 16'h01);

        // hold mode keeps the last result
        press(2'b01);
        check("mode_hold", bus.mode, 16'h3);
        set_ops(2'b00, 4'd0, 4'd0); tick(2);
        check("hold_result", bus.result, 16'h01);

        // wrap both ways and simultaneous press
        press(2'b01); check("wrap_up", bus.mode, 16'h0);
        press(2'b10); check("wrap_down", bus.mode, 16'h3);
        press(2'b11); check("both_keys", bus.mode, 16'h3);
        press(2'b01); check("back_arith", bus.mode, 16'h0);

        // arithmetic
        set_ops(2'b00, 4'd9, 4'd8);   tick(1);
        check("add_res", bus.result, 16'h11); check("add_ovf", bus.ovf, 16'h1);
        set_ops(2'b01, 4'd3, 4'd5);   tick(1);
        check("sub_res", bus.result, 16'h0E); check("sub_ovf", bus.ovf, 16'h1);
        set_ops(2'b10, 4'd15, 4'd15); tick(1);
        check("mul_res", bus.result, 16'hE1); check("mul_ovf", bus.ovf, 16'h0);
        set_ops(2'b00, 4'd3, 4'd4);   tick(1);
        check("add_nc_res", bus.result, 16'h07); check("add_nc_ovf", bus.ovf, 16'h0);
        set_ops(2'b01, 4'd5, 4'd3);   tick(1);
        check("sub_nb_res", bus.result, 16'h02); check("sub_nb_ovf", bus.ovf, 16'h0);

        // divide 13/4
        set_ops(2'b11, 4'd13, 4'd4);
        tick(1); check("div_busy_rise", bus.busy, 16'h1);
        check("div_hold_res", bus.result, 16'h02);
        tick(3); check("div_busy_c4", bus.busy, 16'h1);
        tick(1); check("div_busy_fall", bus.busy, 16'h0);
        check("div_res_early", bus.result, 16'h02);
        tick(1); check("div_res", bus.result, 16'h13);
        check("div_ovf", bus.ovf, 16'h0);
        tick(3); check("div_no_repeat", bus.busy, 16'h0);

        // divide by zero
        bus.y = 4'd0;
        tick(1); check("dz_res", bus.result, 16'hFF); check("dz_ovf", bus.ovf, 16'h1);
        check("dz_busy", bus.busy, 16'h0);
        tick(2); check("dz_busy_late", bus.busy, 16'h0);

        // operand change mid-divide restarts
        bus.y = 4'd4;
        tick(2); check("rs_busy", bus.busy, 16'h1);
        bus.y = 4'd3;
        tick(4); check("rs_res_mid", bus.result, 16'hFF);
        tick(2); check("rs_res", bus.result, 16'h14);
        check("rs_busy_done", bus.busy, 16'h0);

        // mode switched to hold mid-divide
        bus.key = 2'b01;
        tick(4);
        bus.x = 4'd14;
        tick(1); check("ab_busy", bus.busy, 16'h1);
        tick(1); check("ab_mode", bus.mode, 16'h3);
        check("ab_busy_still", bus.busy, 16'h1);
        tick(1); check("ab_busy_fall", bus.busy, 16'h0);
        bus.key = 2'b11;
        set_ops(2'b00, 4'd1, 4'd1);
        tick(8);
        check("ab_res", bus.result, 16'h14);

        // back to arithmetic: pending divide 14/3 runs
        set_ops(2'b11, 4'd14, 4'd3);
        press(2'b01);
        check("div2_mode", bus.mode, 16'h0);
        check("div2_res", bus.result, 16'h24);

        // async reset mid-divide
        bus.x = 4'd13; bus.y = 4'd4;
        tick(2); check("rd_busy", bus.busy, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rd_res", bus.result, 16'h00);
        check("rd_busy0", bus.busy, 16'h0);
        check("rd_mode", bus.mode, 16'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1); check("rd_restart", bus.busy, 16'h1);
        tick(5); check("rd_res2", bus.result, 16'h13);

        press(2'b01);
        press(2'b01);
        check("rd_mode2", bus.mode, 16'h2);
        set_ops(2'b11, 4'd6, 4'd9);
        tick(1); check("rd_max", bus.result, 16'h09);

        // key held across reset release
        bus.key = 2'b10;
        tick(2);
        #2 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(15);
        check("held_rst_mode", bus.mode, 16'h0);
        bus.key = 2'b11;
        tick(8);
        press(2'b01);
        check("held_rel_press", bus.mode, 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
